bus_arbiter: RTL

Shares one single-ported unified memory bus between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store, including ll/sc).
Registered FSM with a fixed-latency wait counter and round-robin tie-break.
Returns read data with a one-cycle ack pulse and drives a pipeline stall while any request is unacknowledged.
Sits between IF/MEM and the external RAM.

---
 rtl/bus_arb_pkg.sv | 29 ++
 rtl/bus_arb_perf.sv | 30 +++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared encodings and limits for the IF/MEM memory bus arbiter
//   arbStateT : arbiter FSM state (IDLE/FETCH/DATA)
//   grantT    : requester identity used for grant and round-robin history
//   pickGrant : round-robin choice between the eligible requesters
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arbStateT;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grantT;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;
  localparam int PERF_W      = 32;

  // A lone eligible requester wins outright; on a tie the one not served last wins.
  function automatic grantT pickGrant(input logic ifElig, input logic dElig, input grantT lastGrant);
    return (ifElig & dElig) ? ((lastGrant == GNT_FETCH) ? GNT_DATA : GNT_FETCH)
         : dElig ? GNT_DATA : GNT_FETCH;
  endfunction

endpackage

// File: rtl/bus_arb_perf.sv
// bus_arb_perf: free-running stall and grant event counters for the bus arbiter
//   clk, rst(async, active-low)
//   stall, ifGrant, dGrant : one-cycle event strobes from the arbiter
//   perfStall, perfIfGrant, perfDGrant : wrapping event counts
module bus_arb_perf
  import bus_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ifGrant,
  input  logic              dGrant,
  output logic [PERF_W-1:0] perfStall,
  output logic [PERF_W-1:0] perfIfGrant,
  output logic [PERF_W-1:0] perfDGrant
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfStall   <= '0;
      perfIfGrant <= '0;
      perfDGrant  <= '0;
    end else begin
      perfStall   <= perfStall + PERF_W'(stall);
      perfIfGrant <= perfIfGrant + PERF_W'(ifGrant);
      perfDGrant  <= perfDGrant + PERF_W'(dGrant);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-ported memory bus between instruction fetch and load/store
//   clk, rst(async, active-low)
//   ifReq/ifAddr -> ifRdata/ifAck        : fetch requester
//   dReq/dWr/dAddr/dWdata -> dRdata/dAck : load/store requester
//   excpt : flush; drops the ack of an in-flight fetch
//   stall : high while any request is still unacknowledged
//   busCe/busWr/busAddr/busWdata, busRdata : external RAM port, MEM_LAT cycles per access
//   Optional macro BUS_ARB_PERF_EN adds perfStall/perfIfGrant/perfDGrant counters.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifAck,
  input  logic              dReq,
  input  logic              dWr,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic [DATA_W-1:0] dRdata,
  output logic              dAck,
  input  logic              excpt,
  output logic              stall,
  output logic              busCe,
  output logic              busWr,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWdata,
  input  logic [DATA_W-1:0] busRdata
`ifdef BUS_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perfStall,
  output logic [PERF_W-1:0] perfIfGrant,
  output logic [PERF_W-1:0] perfDGrant
`endif
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : gLatRange
    $error("bus_arbiter: MEM_LAT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arbStateT          state, stateNext;
  grantT             lastGrant, grantSel;
  logic [CNT_W-1:0]  cnt;
  logic              dropFetch;
  logic              ifElig, dElig, grantValid, lastCycle;
  logic              ifAckNext, dAckNext, loadDone, busWrNext;
  logic [ADDR_W-1:0] busAddrNext;
  logic [DATA_W-1:0] busWdataNext;

  // A requester whose ack is showing this cycle is finished; its still-high
  // request line belongs to the completed access, not a new one.
  assign ifElig     = ifReq & ~ifAck;
  assign dElig      = dReq & ~dAck;
  assign stall      = ifElig | dElig;
  assign grantValid = (state == IDLE) & (ifElig | dElig);
  assign grantSel   = pickGrant(ifElig, dElig, lastGrant);
  assign lastCycle  = (state != IDLE) & (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = grantValid ? ((grantSel == GNT_DATA) ? DATA : FETCH)
              : lastCycle  ? IDLE : state;
  end

  // Next values of the registered outputs; the bus fields load on grant,
  // hold through the access and clear once the final data beat is taken.
  always_comb begin
    ifAckNext    = lastCycle & (state == FETCH) & ~dropFetch & ~excpt;
    dAckNext     = lastCycle & (state == DATA);
    loadDone     = dAckNext & ~busWr;
    busAddrNext  = grantValid ? ((grantSel == GNT_DATA) ? dAddr : ifAddr)
                 : lastCycle  ? '0 : busAddr;
    busWrNext    = grantValid ? ((grantSel == GNT_DATA) & dWr)
                 : lastCycle  ? 1'b0 : busWr;
    busWdataNext = (grantValid & (grantSel == GNT_DATA)) ? dWdata
                 : (grantValid | lastCycle) ? '0 : busWdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lastGrant <= GNT_FETCH;
      dropFetch <= 1'b0;
      busCe     <= 1'b0;
      busWr     <= 1'b0;
      busAddr   <= '0;
      busWdata  <= '0;
      ifAck     <= 1'b0;
      dAck      <= 1'b0;
      ifRdata   <= '0;
      dRdata    <= '0;
    end else begin
      cnt       <= grantValid ? CNT_LOAD : (state != IDLE && cnt != '0) ? cnt - 1'b1 : cnt;
      lastGrant <= grantValid ? grantSel : lastGrant;
      dropFetch <= lastCycle ? 1'b0 : (dropFetch | ((state == FETCH) & excpt));
      busCe     <= (stateNext != IDLE);
      busWr     <= busWrNext;
      busAddr   <= busAddrNext;
      busWdata  <= busWdataNext;
      ifAck     <= ifAckNext;
      dAck      <= dAckNext;
      ifRdata   <= ifAckNext ? busRdata : ifRdata;
      dRdata    <= loadDone ? busRdata : dRdata;
    end
  end

`ifdef BUS_ARB_PERF_EN
  bus_arb_perf uPerf (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .ifGrant    (grantValid & (grantSel == GNT_FETCH)),
    .dGrant     (grantValid & (grantSel == GNT_DATA)),
    .perfStall  (perfStall),
    .perfIfGrant(perfIfGrant),
    .perfDGrant (perfDGrant)
  );
`endif

endmodule
